// File: rtl/round_controller.sv
// Game-round sequencer for the binary number game.
// Generates targets from a 4-bit LFSR, judges guesses using the comparator's
// match flag, and tracks score, lives and a per-round tick countdown.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | after reset, waiting for start
// NEW_ROUND | single cycle: load a fresh target and reload the round timer
// WAIT      | round running: waiting for submit or for the timer to expire
// OVER      | out of lives: target/score/time frozen until start
module round_controller #(
    parameter int unsigned ROUND_TIME = 10,
    parameter int unsigned LIVES      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       submit,
    input  logic       tick,
    input  logic       match,
    output logic [3:0] target,
    output logic [3:0] time_left,
    output logic [1:0] lives,
    output logic [7:0] score,
    output logic       playing,
    output logic       game_over,
    output logic       win_pulse,
    output logic       fail_pulse
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        NEW_ROUND = 2'd1,
        WAIT      = 2'd2,
        OVER      = 2'd3
    } state_t;

    localparam logic [3:0] ROUND_TIME_L = 4'(ROUND_TIME);
    localparam logic [1:0] LIVES_L      = 2'(LIVES);

    state_t     state, state_nxt;
    logic [3:0] lfsr, lfsr_nxt;
    logic [3:0] target_nxt;
    logic [3:0] time_left_nxt;
    logic [1:0] lives_nxt;
    logic [7:0] score_nxt;
    logic       win_nxt;
    logic       fail_nxt;
    logic       playing_nxt;
    logic       game_over_nxt;

    // Next-state and next-output decode; pulse outputs default low every cycle.
    always_comb begin
        state_nxt     = state;
        target_nxt    = target;
        time_left_nxt = time_left;
        lives_nxt     = lives;
        score_nxt     = score;
        win_nxt       = 1'b0;
        fail_nxt      = 1'b0;
        // Shifting a nonzero seed through x^4+x^3+1 never reaches zero.
        lfsr_nxt      = {lfsr[2:0], lfsr[3] ^ lfsr[2]};

        case (state)
            IDLE, OVER: begin
                if (start) begin
                    lives_nxt = LIVES_L;
                    score_nxt = 8'd0;
                    state_nxt = NEW_ROUND;
                end
            end
            NEW_ROUND: begin
                target_nxt    = lfsr;
                time_left_nxt = ROUND_TIME_L;
                state_nxt     = WAIT;
            end
            WAIT: begin
                // submit outranks tick, so a coincident tick is simply lost.
                if (submit && match) begin
                    score_nxt = (score == 8'hFF) ? score : score + 8'd1;
                    win_nxt   = 1'b1;
                    state_nxt = NEW_ROUND;
                end else if (submit) begin
                    fail_nxt  = 1'b1;
                    lives_nxt = lives - 2'd1;
                    if (lives == 2'd1) begin
                        state_nxt = OVER;
                    end
                end else if (tick && (time_left == 4'd1)) begin
                    fail_nxt      = 1'b1;
                    time_left_nxt = 4'd0;
                    lives_nxt     = lives - 2'd1;
                    state_nxt     = (lives == 2'd1) ? OVER : NEW_ROUND;
                end else if (tick && (time_left > 4'd1)) begin
                    time_left_nxt = time_left - 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Status flags are decoded from the next state so they leave a flop.
        playing_nxt   = (state_nxt == NEW_ROUND) || (state_nxt == WAIT);
        game_over_nxt = (state_nxt == OVER);
    end

    // State, LFSR and all output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lfsr       <= 4'b0001;
            target     <= 4'd0;
            time_left  <= 4'd0;
            lives      <= 2'd0;
            score      <= 8'd0;
            playing    <= 1'b0;
            game_over  <= 1'b0;
            win_pulse  <= 1'b0;
            fail_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            lfsr       <= lfsr_nxt;
            target     <= target_nxt;
            time_left  <= time_left_nxt;
            lives      <= lives_nxt;
            score      <= score_nxt;
            playing    <= playing_nxt;
            game_over  <= game_over_nxt;
            win_pulse  <= win_nxt;
            fail_pulse <= fail_nxt;
        end
    end

endmodule

// File: tb/tb_round_controller.sv
// Bench for round_controller: directed game scenarios followed by randomized
// play, every cycle checked against a behavioural model of the game rules.
module tb_round_controller;

    localparam int ROUND_TIME = 10;
    localparam int LIVES      = 3;

    logic       clk = 1'b0;
    logic       rst, start, submit, tick, match;
    logic [3:0] target, time_left;
    logic [1:0] lives;
    logic [7:0] score;
    logic       playing, game_over, win_pulse, fail_pulse;

    int n_cmp = 0;
    int n_err = 0;

    round_controller #(.ROUND_TIME(ROUND_TIME), .LIVES(LIVES)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .submit     (submit),
        .tick       (tick),
        .match      (match),
        .target     (target),
        .time_left  (time_left),
        .lives      (lives),
        .score      (score),
        .playing    (playing),
        .game_over  (game_over),
        .win_pulse  (win_pulse),
        .fail_pulse (fail_pulse)
    );

    always #5 clk = ~clk;

    // Reference model: game phase plus plain integer bookkeeping.
    localparam int PH_IDLE = 0, PH_LOAD = 1, PH_PLAY = 2, PH_OVER = 3;
    int m_phase, m_rng, m_target, m_time, m_lives, m_score;
    bit m_win, m_fail;

    task automatic model_step(input bit r, input bit s, input bit sb, input bit tk, input bit mt);
        int old_rng;
        if (r) begin
            m_phase = PH_IDLE; m_rng = 1; m_target = 0; m_time = 0;
            m_lives = 0; m_score = 0; m_win = 0; m_fail = 0;
            return;
        end
        old_rng = m_rng;
        m_rng   = ((m_rng * 2) % 16) + (((m_rng / 8) + (m_rng / 4)) % 2);
        m_win   = 0;
        m_fail  = 0;
        if (m_phase == PH_IDLE || m_phase == PH_OVER) begin
            if (s) begin
                m_lives = LIVES; m_score = 0; m_phase = PH_LOAD;
            end
        end else if (m_phase == PH_LOAD) begin
            m_target = old_rng; m_time = ROUND_TIME; m_phase = PH_PLAY;
        end else if (sb && mt) begin
            m_score = (m_score < 255) ? m_score + 1 : 255;
            m_win = 1; m_phase = PH_LOAD;
        end else if (sb) begin
            m_fail = 1; m_lives = m_lives - 1;
            if (m_lives == 0) m_phase = PH_OVER;
        end else if (tk && m_time == 1) begin
            m_fail = 1; m_time = 0; m_lives = m_lives - 1;
            m_phase = (m_lives == 0) ? PH_OVER : PH_LOAD;
        end else if (tk) begin
            m_time = m_time - 1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs at negedge, step the model at posedge, compare 1 ns later.
    task automatic cyc(input bit r, input bit s, input bit sb, input bit tk, input bit mt);
        @(negedge clk);
        rst = r; start = s; submit = sb; tick = tk; match = mt;
        @(posedge clk);
        model_step(r, s, sb, tk, mt);
        #1;
        check("target",     32'(target),     32'(m_target));
        check("time_left",  32'(time_left),  32'(m_time));
        check("lives",      32'(lives),      32'(m_lives));
        check("score",      32'(score),      32'(m_score));
        check("playing",    32'(playing),    32'(m_phase == PH_LOAD || m_phase == PH_PLAY));
        check("game_over",  32'(game_over),  32'(m_phase == PH_OVER));
        check("win_pulse",  32'(win_pulse),  32'(m_win));
        check("fail_pulse", 32'(fail_pulse), 32'(m_fail));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    initial begin
        int last_sub;
        int sub_pct;
        bit s, sb, tk, mt, r;
        rst = 1; start = 0; submit = 0; tick = 0; match = 0;

        // Reset and idle.
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        idle(5);

        // Start, then a correct guess and the reload two edges later.
        cyc(0, 1, 0, 0, 0);
        idle(2);
        cyc(0, 0, 1, 0, 1);
        idle(3);

        // Run the timer down to 1, then submit+tick together: submit wins.
        for (int i = 0; i < 40 && m_time != 1; i++) cyc(0, 0, 0, (i % 2) == 0, 0);
        check("time_at_one", 32'(time_left), 32'd1);
        cyc(0, 0, 1, 1, 1);
        idle(2);

        // Three wrong guesses to game over.
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 0, 0);
            cyc(0, 0, 0, 1, 0);
        end
        check("over_after_wrong", 32'(game_over), 32'd1);
        cyc(0, 0, 1, 1, 0);

        // Restart from OVER, then a full timeout.
        cyc(0, 1, 0, 0, 0);
        idle(2);
        for (int i = 0; i < ROUND_TIME; i++) begin
            cyc(0, 0, 0, 1, 0);
            cyc(0, 0, 0, 0, 0);
        end
        check("lives_after_timeout", 32'(lives), 32'd2);

        // Long streak of correct guesses to hit score saturation.
        for (int i = 0; i < 262; i++) begin
            cyc(0, 0, 1, 0, 1);
            cyc(0, 0, 0, 0, 0);
        end
        check("score_saturated", 32'(score), 32'd255);

        // Reset mid-game.
        cyc(1, 0, 0, 0, 0);
        idle(3);

        // Randomized play; the second half makes submits rare so timeouts occur.
        last_sub = -10;
        for (int i = 0; i < 4000; i++) begin
            sub_pct = (i < 2000) ? 12 : 2;
            r  = ($urandom_range(0, 499) == 0);
            s  = ($urandom_range(0, 99) < 5);
            tk = ($urandom_range(0, 99) < 30);
            mt = $urandom_range(0, 1) == 1;
            sb = ($urandom_range(0, 99) < sub_pct) && (i - last_sub >= 2);
            if (sb) last_sub = i;
            cyc(r, s, sb, tk, mt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
